m_inst_fetch: RTL and testbench

M_INST_FETCH -- requirements
Module: m_inst_fetch

---
 rtl/m_inst_fetch.sv | 149 ++++++++++++++
 tb/tb_m_inst_fetch.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_inst_fetch.sv
// m_inst_fetch: PC generator feeding a 1-cycle synchronous instruction memory, with a 2-entry {pc,inst} buffer.
// Define FETCH_PERF_EN to enable the stall-cycle counter on w_perf_stall_cnt (tied to zero otherwise).
module m_inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  output logic [31:0] w_mem_addr,
  output logic        w_mem_req,
  input  logic [31:0] w_mem_rdata,
  input  logic        w_redirect,
  input  logic [31:0] w_redirect_pc,
  output logic        w_out_valid,
  output logic [31:0] w_out_inst,
  output logic [31:0] w_out_pc,
  input  logic        w_out_ready,
  output logic [31:0] w_perf_stall_cnt
);

  logic [31:0] pc_r;
  logic        infl_r;
  logic [31:0] infl_pc_r;
  logic        head_valid_r;
  logic [31:0] head_pc_r;
  logic [31:0] head_inst_r;
  logic        tail_valid_r;
  logic [31:0] tail_pc_r;
  logic [31:0] tail_inst_r;

  logic        pop_s;
  logic        push_s;
  logic [1:0]  occ_s;
  logic        nxt_head_valid_s;
  logic [31:0] nxt_head_pc_s;
  logic [31:0] nxt_head_inst_s;
  logic        nxt_tail_valid_s;
  logic [31:0] nxt_tail_pc_s;
  logic [31:0] nxt_tail_inst_s;
  logic        unused_s;

  assign pop_s  = head_valid_r & w_out_ready;
  assign push_s = infl_r & ~w_redirect;
  assign occ_s  = {1'b0, head_valid_r} + {1'b0, tail_valid_r} + {1'b0, infl_r} - {1'b0, pop_s};

  // A redirect empties the buffer and kills the in-flight word, so it may always fetch its target.
  assign w_mem_req  = w_rst_n & (w_redirect | (occ_s < 2'd2));
  assign w_mem_addr = w_redirect ? {w_redirect_pc[31:2], 2'b00} : pc_r;
  assign unused_s   = ^w_redirect_pc[1:0];

  assign w_out_valid = head_valid_r;
  assign w_out_pc    = head_pc_r;
  assign w_out_inst  = head_inst_r;

  // Buffer next state: a pop shifts the tail forward, the returning word fills the first free slot.
  always_comb begin
    nxt_head_valid_s = head_valid_r;
    nxt_head_pc_s    = head_pc_r;
    nxt_head_inst_s  = head_inst_r;
    nxt_tail_valid_s = tail_valid_r;
    nxt_tail_pc_s    = tail_pc_r;
    nxt_tail_inst_s  = tail_inst_r;
    case ({pop_s, push_s})
      2'b10: begin
        nxt_head_valid_s = tail_valid_r;
        nxt_head_pc_s    = tail_pc_r;
        nxt_head_inst_s  = tail_inst_r;
        nxt_tail_valid_s = 1'b0;
      end
      2'b01: begin
        if (head_valid_r) begin
          nxt_tail_valid_s = 1'b1;
          nxt_tail_pc_s    = infl_pc_r;
          nxt_tail_inst_s  = w_mem_rdata;
        end else begin
          nxt_head_valid_s = 1'b1;
          nxt_head_pc_s    = infl_pc_r;
          nxt_head_inst_s  = w_mem_rdata;
        end
      end
      2'b11: begin
        if (tail_valid_r) begin
          nxt_head_valid_s = 1'b1;
          nxt_head_pc_s    = tail_pc_r;
          nxt_head_inst_s  = tail_inst_r;
          nxt_tail_valid_s = 1'b1;
          nxt_tail_pc_s    = infl_pc_r;
          nxt_tail_inst_s  = w_mem_rdata;
        end else begin
          nxt_head_valid_s = 1'b1;
          nxt_head_pc_s    = infl_pc_r;
          nxt_head_inst_s  = w_mem_rdata;
          nxt_tail_valid_s = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  // PC, in-flight tracker and buffer registers.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      pc_r         <= RESET_PC;
      infl_r       <= 1'b0;
      infl_pc_r    <= 32'h0000_0000;
      head_valid_r <= 1'b0;
      head_pc_r    <= 32'h0000_0000;
      head_inst_r  <= 32'h0000_0000;
      tail_valid_r <= 1'b0;
      tail_pc_r    <= 32'h0000_0000;
      tail_inst_r  <= 32'h0000_0000;
    end else begin
      if (w_mem_req) begin
        pc_r <= w_mem_addr + 32'd4;
      end
      infl_r      <= w_mem_req;
      infl_pc_r   <= w_mem_addr;
      head_pc_r   <= nxt_head_pc_s;
      head_inst_r <= nxt_head_inst_s;
      tail_pc_r   <= nxt_tail_pc_s;
      tail_inst_r <= nxt_tail_inst_s;
      if (w_redirect) begin
        head_valid_r <= 1'b0;
        tail_valid_r <= 1'b0;
      end else begin
        head_valid_r <= nxt_head_valid_s;
        tail_valid_r <= nxt_tail_valid_s;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_r;

  // Count cycles where a valid instruction is held back by downstream.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      stall_cnt_r <= 32'd0;
    end else if (head_valid_r && !w_out_ready) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign w_perf_stall_cnt = stall_cnt_r;
`else
  assign w_perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_m_inst_fetch.sv
// Scoreboard bench for m_inst_fetch: expected program-order stream queued by stimulus, checked by a monitor.
module tb_m_inst_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        w_clk = 1'b0;
  logic        w_rst_n;
  logic [31:0] w_mem_addr;
  logic        w_mem_req;
  logic [31:0] w_mem_rdata;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_out_valid;
  logic [31:0] w_out_inst;
  logic [31:0] w_out_pc;
  logic        w_out_ready;
  logic [31:0] w_perf_stall_cnt;

  m_inst_fetch #(.RESET_PC(RST_PC)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .w_mem_addr(w_mem_addr), .w_mem_req(w_mem_req),
    .w_mem_rdata(w_mem_rdata), .w_redirect(w_redirect), .w_redirect_pc(w_redirect_pc),
    .w_out_valid(w_out_valid), .w_out_inst(w_out_inst), .w_out_pc(w_out_pc),
    .w_out_ready(w_out_ready), .w_perf_stall_cnt(w_perf_stall_cnt)
  );

  always #5 w_clk = ~w_clk;

  // word[0..2]=n, word[3]=4, word[n]=n*16 otherwise
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] n;
    n = a >> 2;
    if (n < 32'd3) return n;
    else if (n == 32'd3) return 32'd4;
    else return n << 4;
  endfunction

  always @(posedge w_clk) w_mem_rdata <= mem_word(w_mem_addr);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [15:0] gen;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [15:0] gen_cur = 16'd0;
  logic [15:0] active_gen = 16'd0;
  logic [31:0] next_pc = RST_PC;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          stall_model = 0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_pc;
  logic [31:0] prev_inst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push_expect();
    exp_q.push_back('{pc: next_pc, inst: mem_word(next_pc), gen: gen_cur});
    next_pc = next_pc + 32'd4;
  endtask

  task automatic top_up();
    int n = 0;
    foreach (exp_q[k]) if (exp_q[k].gen == gen_cur) n++;
    while (n < 4) begin
      push_expect();
      n++;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    gen_cur = gen_cur + 16'd1;
    next_pc = RST_PC;
    repeat (4) push_expect();
  endtask

  task automatic issue_redirect(input logic [31:0] tgt);
    w_redirect    = 1'b1;
    w_redirect_pc = tgt;
    gen_cur       = gen_cur + 16'd1;
    next_pc       = {tgt[31:2], 2'b00};
    repeat (4) push_expect();
  endtask

  task automatic next_cycle();
    @(posedge w_clk);
    #1;
    cyc++;
    w_redirect = 1'b0;
    top_up();
  endtask

  task automatic assert_reset();
    w_rst_n = 1'b0;
    w_redirect = 1'b0;
    model_reset();
  endtask

  task automatic release_reset();
    @(posedge w_clk);
    #1;
    w_rst_n = 1'b1;
    cyc = 0;
    w_redirect = 1'b0;
  endtask

  task automatic do_reset();
    assert_reset();
    repeat (2) @(posedge w_clk);
    release_reset();
  endtask

  // Monitor: compares every transfer against the queue head of the live stream generation.
  always @(negedge w_clk) begin
    if (!w_rst_n) begin
      active_gen  = gen_cur;
      stall_model = 0;
      prev_hold   = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", {31'd0, w_out_valid}, 32'd1);
        check("hold_pc", w_out_pc, prev_pc);
        check("hold_inst", w_out_inst, prev_inst);
      end
      if (w_out_valid && w_out_ready) begin
        while (exp_q.size() > 0 && exp_q[0].gen != active_gen) void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          check("sb_underflow", w_out_pc, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          check("out_pc", w_out_pc, e.pc);
          check("out_inst", w_out_inst, e.inst);
        end
      end
      if (w_redirect) begin
        check("redir_addr", w_mem_addr, {w_redirect_pc[31:2], 2'b00});
        check("redir_req", {31'd0, w_mem_req}, 32'd1);
        active_gen = gen_cur;
      end
`ifdef FETCH_PERF_EN
      check("perf_cnt", w_perf_stall_cnt, 32'(stall_model));
`else
      check("perf_cnt", w_perf_stall_cnt, 32'd0);
`endif
      if (w_out_valid && !w_out_ready) stall_model++;
      prev_hold = w_out_valid && !w_out_ready && !w_redirect;
      prev_pc   = w_out_pc;
      prev_inst = w_out_inst;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] tgt;
    w_rst_n = 1'b0; w_redirect = 1'b0; w_redirect_pc = 32'd0; w_out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge w_clk);
    @(negedge w_clk);
    check("rst_valid", {31'd0, w_out_valid}, 32'd0);
    check("rst_inst", w_out_inst, 32'd0);
    check("rst_pc", w_out_pc, 32'd0);
    check("rst_req", {31'd0, w_mem_req}, 32'd0);
    check("rst_perf", w_perf_stall_cnt, 32'd0);

    // Streaming from reset with ready held high
    release_reset();
    w_out_ready = 1'b1;
    @(negedge w_clk);
    check("first_req", {31'd0, w_mem_req}, 32'd1);
    check("first_addr", w_mem_addr, RST_PC);
    next_cycle();
    @(negedge w_clk);
    check("lat_c1_valid", {31'd0, w_out_valid}, 32'd0);
    for (int c = 2; c <= 5; c++) begin
      next_cycle();
      @(negedge w_clk);
      check("stream_valid", {31'd0, w_out_valid}, 32'd1);
      check("stream_pc", w_out_pc, 32'(4 * (c - 2)));
    end

    // Backpressure for cycles 2..6
    do_reset();
    w_out_ready = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      w_out_ready = !(c >= 2 && c <= 6);
      @(negedge w_clk);
      if (c >= 2 && c <= 6) begin
        check("bp_req_low", {31'd0, w_mem_req}, 32'd0);
        check("bp_head_pc", w_out_pc, 32'd0);
      end
      if (c >= 7 && c <= 9) check("bp_no_gap", {31'd0, w_out_valid}, 32'd1);
`ifdef FETCH_PERF_EN
      if (c == 7) check("perf_five", w_perf_stall_cnt, 32'd5);
`else
      if (c == 7) check("perf_off", w_perf_stall_cnt, 32'd0);
`endif
    end

    // Redirect to 0x42 in cycle 4
    do_reset();
    w_out_ready = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      if (c == 4) issue_redirect(32'h0000_0042);
      @(negedge w_clk);
      if (c == 4) check("redir_mem_addr", w_mem_addr, 32'h0000_0040);
      if (c == 5) check("redir_bubble", {31'd0, w_out_valid}, 32'd0);
      if (c == 6) begin
        check("redir_lat_valid", {31'd0, w_out_valid}, 32'd1);
        check("redir_lat_pc", w_out_pc, 32'h0000_0040);
        check("redir_lat_inst", w_out_inst, 32'h0000_0100);
      end
    end

    // Redirect with simultaneous transfer, then redirect again to 0x20
    do_reset();
    w_out_ready = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      if (c == 3) issue_redirect(32'h0000_0080);
      if (c == 4) issue_redirect(32'h0000_0020);
      @(negedge w_clk);
      if (c == 3) check("dbl_xfer_valid", {31'd0, w_out_valid}, 32'd1);
      if (c == 4 || c == 5) check("dbl_cleared", {31'd0, w_out_valid}, 32'd0);
      if (c == 6) check("dbl_target_pc", w_out_pc, 32'h0000_0020);
    end

    // Redirect near the top of the address space wraps to zero
    do_reset();
    w_out_ready = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      if (c == 3) issue_redirect(32'hFFFF_FFFE);
      @(negedge w_clk);
      if (c == 5) check("wrap_top_pc", w_out_pc, 32'hFFFF_FFFC);
      if (c == 6) begin
        check("wrap_zero_valid", {31'd0, w_out_valid}, 32'd1);
        check("wrap_zero_pc", w_out_pc, 32'h0000_0000);
      end
    end

    // Reset asserted mid-stall
    do_reset();
    w_out_ready = 1'b0;
    repeat (5) next_cycle();
    assert_reset();
    #1;
    check("midrst_valid", {31'd0, w_out_valid}, 32'd0);
    check("midrst_perf", w_perf_stall_cnt, 32'd0);
    check("midrst_pc", w_out_pc, 32'd0);
    check("midrst_req", {31'd0, w_mem_req}, 32'd0);
    repeat (2) @(posedge w_clk);
    release_reset();

    // Randomized traffic: ready, redirects and occasional resets
    w_out_ready = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      w_out_ready = ($urandom_range(0, 9) < 7);
      if (i % 700 == 350) begin
        assert_reset();
        #1;
        check("rnd_rst_valid", {31'd0, w_out_valid}, 32'd0);
        repeat (2) @(posedge w_clk);
        release_reset();
      end else if ($urandom_range(0, 99) < 5) begin
        tgt = $urandom;
        if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'h0000_000F);
        issue_redirect(tgt);
      end
    end
    repeat (4) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
